// File: rtl/host_device_bus.sv
// Fixed-priority N-host to M-device interconnect with a combinational request
// path and response steering registered at the grant edge.
module host_device_bus #(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    host_req_i            [NrHosts],
  output logic                    host_gnt_o            [NrHosts],
  input  logic [AddressWidth-1:0] host_addr_i           [NrHosts],
  input  logic                    host_we_i             [NrHosts],
  input  logic [DataWidth/8-1:0]  host_be_i             [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i          [NrHosts],
  output logic                    host_rvalid_o         [NrHosts],
  output logic [DataWidth-1:0]    host_rdata_o          [NrHosts],
  output logic                    host_err_o            [NrHosts],

  output logic                    device_req_o          [NrDevices],
  output logic [AddressWidth-1:0] device_addr_o         [NrDevices],
  output logic                    device_we_o           [NrDevices],
  output logic [DataWidth/8-1:0]  device_be_o           [NrDevices],
  output logic [DataWidth-1:0]    device_wdata_o        [NrDevices],
  input  logic                    device_rvalid_i       [NrDevices],
  input  logic [DataWidth-1:0]    device_rdata_i        [NrDevices],
  input  logic                    device_err_i          [NrDevices],

  input  logic [AddressWidth-1:0] cfg_device_addr_base  [NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_mask  [NrDevices]
);

  localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int BeWidth  = DataWidth / 8;

  logic                    host_sel_valid;
  logic [HostIdxW-1:0]     host_sel_req;
  logic [AddressWidth-1:0] sel_addr;
  logic                    sel_we;
  logic [BeWidth-1:0]      sel_be;
  logic [DataWidth-1:0]    sel_wdata;

  logic                    dev_sel_valid;
  logic [DevIdxW-1:0]      dev_sel;

  logic [HostIdxW-1:0]     resp_host;
  logic [DevIdxW-1:0]      resp_device;
  logic                    resp_unmapped;

  logic                    dev_rvalid;
  logic [DataWidth-1:0]    dev_rdata;
  logic                    dev_err;

  // Scanning from the top index down leaves the lowest requesting host as winner.
  always_comb begin
    host_sel_valid = 1'b0;
    host_sel_req   = '0;
    sel_addr       = '0;
    sel_we         = 1'b0;
    sel_be         = '0;
    sel_wdata      = '0;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (host_req_i[h]) begin
        host_sel_valid = 1'b1;
        host_sel_req   = HostIdxW'(h);
        sel_addr       = host_addr_i[h];
        sel_we         = host_we_i[h];
        sel_be         = host_be_i[h];
        sel_wdata      = host_wdata_i[h];
      end
    end
  end

  always_comb begin
    dev_sel_valid = 1'b0;
    dev_sel       = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((sel_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        dev_sel_valid = 1'b1;
        dev_sel       = DevIdxW'(d);
      end
    end
  end

  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      host_gnt_o[h] = host_sel_valid && (host_sel_req == HostIdxW'(h));
    end
  end

  // Payload fans out to every device; only the strobe is qualified by decode.
  always_comb begin
    for (int d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = host_sel_valid && dev_sel_valid && (dev_sel == DevIdxW'(d));
      device_addr_o[d]  = sel_addr;
      device_we_o[d]    = sel_we;
      device_be_o[d]    = sel_be;
      device_wdata_o[d] = sel_wdata;
    end
  end

  // The unmapped flag only lives for the cycle after its grant, so an idle bus
  // does not keep replaying the internally generated error response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_host     <= '0;
      resp_device   <= '0;
      resp_unmapped <= 1'b0;
    end else begin
      resp_unmapped <= host_sel_valid && !dev_sel_valid;
      if (host_sel_valid) begin
        resp_host   <= host_sel_req;
        resp_device <= dev_sel_valid ? dev_sel : '0;
      end
    end
  end

  always_comb begin
    dev_rvalid = 1'b0;
    dev_rdata  = '0;
    dev_err    = 1'b0;
    for (int d = 0; d < NrDevices; d++) begin
      if (resp_device == DevIdxW'(d)) begin
        dev_rvalid = device_rvalid_i[d];
        dev_rdata  = device_rdata_i[d];
        dev_err    = device_err_i[d];
      end
    end
  end

  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      host_rvalid_o[h] = (resp_host == HostIdxW'(h)) && (resp_unmapped || dev_rvalid);
      host_err_o[h]    = (resp_host == HostIdxW'(h)) && (resp_unmapped || dev_err);
      host_rdata_o[h]  = ((resp_host == HostIdxW'(h)) && !resp_unmapped) ? dev_rdata : '0;
    end
  end

endmodule

// File: tb/tb_host_device_bus.sv
// Directed bench for host_device_bus: two hosts, three devices (RAM, SimCtrl,
// Timer); a vector table for the request path plus hand sequences for responses.
module tb_host_device_bus;

  localparam int NH = 2;
  localparam int ND = 3;

  logic        clk_i;
  logic        rst_ni;
  logic        host_req_i     [NH];
  logic        host_gnt_o     [NH];
  logic [31:0] host_addr_i    [NH];
  logic        host_we_i      [NH];
  logic [3:0]  host_be_i      [NH];
  logic [31:0] host_wdata_i   [NH];
  logic        host_rvalid_o  [NH];
  logic [31:0] host_rdata_o   [NH];
  logic        host_err_o     [NH];
  logic        device_req_o   [ND];
  logic [31:0] device_addr_o  [ND];
  logic        device_we_o    [ND];
  logic [3:0]  device_be_o    [ND];
  logic [31:0] device_wdata_o [ND];
  logic        device_rvalid_i[ND];
  logic [31:0] device_rdata_i [ND];
  logic        device_err_i   [ND];
  logic [31:0] cfg_base       [ND];
  logic [31:0] cfg_mask       [ND];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [1:0]  exp_gnt;
    logic [2:0]  exp_dreq;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[12];

  host_device_bus #(
    .NrDevices(ND), .NrHosts(NH), .DataWidth(32), .AddressWidth(32)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
    .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
    .device_err_i(device_err_i),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_host(input int h, input logic req, input logic [31:0] addr,
                            input logic we, input logic [3:0] be, input logic [31:0] wdata);
    host_req_i[h]   = req;
    host_addr_i[h]  = addr;
    host_we_i[h]    = we;
    host_be_i[h]    = be;
    host_wdata_i[h] = wdata;
  endtask

  task automatic drive_device(input int d, input logic rvalid, input logic [31:0] rdata,
                              input logic err);
    device_rvalid_i[d] = rvalid;
    device_rdata_i[d]  = rdata;
    device_err_i[d]    = err;
  endtask

  task automatic clear_all();
    for (int h = 0; h < NH; h++) drive_host(h, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    for (int d = 0; d < ND; d++) drive_device(d, 1'b0, 32'h0, 1'b0);
  endtask

  function automatic logic [1:0] gnt_bits();
    return {host_gnt_o[1], host_gnt_o[0]};
  endfunction

  function automatic logic [2:0] dreq_bits();
    return {device_req_o[2], device_req_o[1], device_req_o[0]};
  endfunction

  task automatic apply_stimulus(input vec_t v);
    drive_host(0, v.req[0], v.addr0, 1'b0, 4'hF, 32'h0);
    drive_host(1, v.req[1], v.addr1, 1'b0, 4'hF, 32'h0);
    #1;
  endtask

  initial begin
    // RAM, SimCtrl, Timer regions
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;

    vecs[0]  = '{2'b01, 32'h0010_0004, 32'h0,         2'b01, 3'b001, 32'h0010_0004};
    vecs[1]  = '{2'b01, 32'h0002_0000, 32'h0,         2'b01, 3'b010, 32'h0002_0000};
    vecs[2]  = '{2'b01, 32'h0003_0008, 32'h0,         2'b01, 3'b100, 32'h0003_0008};
    vecs[3]  = '{2'b10, 32'h0,         32'h0002_0004, 2'b10, 3'b010, 32'h0002_0004};
    vecs[4]  = '{2'b11, 32'h0003_0000, 32'h0010_0000, 2'b01, 3'b100, 32'h0003_0000};
    vecs[5]  = '{2'b01, 32'h0005_0000, 32'h0,         2'b01, 3'b000, 32'h0005_0000};
    vecs[6]  = '{2'b00, 32'h0010_0000, 32'h0002_0000, 2'b00, 3'b000, 32'h0};
    vecs[7]  = '{2'b10, 32'h0,         32'h001F_FFFC, 2'b10, 3'b001, 32'h001F_FFFC};
    vecs[8]  = '{2'b10, 32'h0,         32'h0020_0000, 2'b10, 3'b000, 32'h0020_0000};
    vecs[9]  = '{2'b01, 32'h0002_03FC, 32'h0,         2'b01, 3'b010, 32'h0002_03FC};
    vecs[10] = '{2'b01, 32'h0002_0400, 32'h0,         2'b01, 3'b000, 32'h0002_0400};
    vecs[11] = '{2'b11, 32'h0003_03FF, 32'h0005_0000, 2'b01, 3'b100, 32'h0003_03FF};

    rst_ni = 1'b0;
    clear_all();
    #1;
    check_output("reset_gnt", 64'(gnt_bits()), 64'h0);
    check_output("reset_rvalid0_idle", 64'(host_rvalid_o[0]), 64'h0);
    device_rvalid_i[0] = 1'b1;
    #1;
    check_output("reset_rvalid0_follows_dev0", 64'(host_rvalid_o[0]), 64'h1);
    check_output("reset_rvalid1", 64'(host_rvalid_o[1]), 64'h0);
    check_output("reset_err0", 64'(host_err_o[0]), 64'h0);
    device_rvalid_i[0] = 1'b0;
    #10 rst_ni = 1'b1;
    next_cycle();

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_gnt", i), 64'(gnt_bits()), 64'(vecs[i].exp_gnt));
      check_output($sformatf("vec%0d_dreq", i), 64'(dreq_bits()), 64'(vecs[i].exp_dreq));
      if (vecs[i].req != 2'b00)
        check_output($sformatf("vec%0d_addr", i), 64'(device_addr_o[2]), 64'(vecs[i].exp_addr));
      next_cycle();
    end
    clear_all();
    next_cycle();

    // RAM read
    drive_host(0, 1'b1, 32'h0010_0004, 1'b0, 4'hF, 32'h0);
    #1;
    check_output("ram_gnt", 64'(gnt_bits()), 64'h1);
    check_output("ram_dreq", 64'(dreq_bits()), 64'h1);
    next_cycle();
    clear_all();
    drive_device(0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    #1;
    check_output("ram_rvalid", 64'(host_rvalid_o[0]), 64'h1);
    check_output("ram_rdata", 64'(host_rdata_o[0]), 64'hDEAD_BEEF);
    check_output("ram_err", 64'(host_err_o[0]), 64'h0);
    check_output("ram_other_rvalid", 64'(host_rvalid_o[1]), 64'h0);
    check_output("ram_other_rdata", 64'(host_rdata_o[1]), 64'h0);
    next_cycle();
    clear_all();

    // SimCtrl byte write
    drive_host(0, 1'b1, 32'h0002_0000, 1'b1, 4'b0001, 32'h41);
    #1;
    check_output("wr_dreq", 64'(dreq_bits()), 64'h2);
    check_output("wr_we", 64'(device_we_o[1]), 64'h1);
    check_output("wr_wdata", 64'(device_wdata_o[1]), 64'h41);
    check_output("wr_be", 64'(device_be_o[1]), 64'h1);
    next_cycle();
    clear_all();
    drive_device(1, 1'b1, 32'h0, 1'b0);
    #1;
    check_output("wr_rvalid0", 64'(host_rvalid_o[0]), 64'h1);
    check_output("wr_rvalid1", 64'(host_rvalid_o[1]), 64'h0);
    next_cycle();
    clear_all();

    // Contention: host 1 holds and wins the following cycle
    drive_host(0, 1'b1, 32'h0010_0000, 1'b0, 4'hF, 32'h0);
    drive_host(1, 1'b1, 32'h0003_0000, 1'b0, 4'hF, 32'h0);
    #1;
    check_output("arb_gnt_first", 64'(gnt_bits()), 64'h1);
    next_cycle();
    host_req_i[0] = 1'b0;
    drive_device(0, 1'b1, 32'h1111_0000, 1'b0);
    #1;
    check_output("arb_gnt_second", 64'(gnt_bits()), 64'h2);
    check_output("arb_dreq_second", 64'(dreq_bits()), 64'h4);
    check_output("arb_rvalid0", 64'(host_rvalid_o[0]), 64'h1);
    check_output("arb_rvalid1_early", 64'(host_rvalid_o[1]), 64'h0);
    next_cycle();
    clear_all();
    drive_device(2, 1'b1, 32'h2222_0000, 1'b0);
    #1;
    check_output("arb_rvalid1", 64'(host_rvalid_o[1]), 64'h1);
    check_output("arb_rdata1", 64'(host_rdata_o[1]), 64'h2222_0000);
    check_output("arb_rvalid0_late", 64'(host_rvalid_o[0]), 64'h0);
    next_cycle();
    clear_all();

    // Unmapped access
    drive_host(0, 1'b1, 32'h0005_0000, 1'b0, 4'hF, 32'h0);
    #1;
    check_output("unm_gnt", 64'(gnt_bits()), 64'h1);
    check_output("unm_dreq", 64'(dreq_bits()), 64'h0);
    next_cycle();
    clear_all();
    drive_device(0, 1'b0, 32'h1234_5678, 1'b0);
    #1;
    check_output("unm_rvalid", 64'(host_rvalid_o[0]), 64'h1);
    check_output("unm_err", 64'(host_err_o[0]), 64'h1);
    check_output("unm_rdata", 64'(host_rdata_o[0]), 64'h0);
    next_cycle();
    clear_all();

    // Timer error response
    drive_host(1, 1'b1, 32'h0003_0008, 1'b0, 4'hF, 32'h0);
    #1;
    check_output("tmr_dreq", 64'(dreq_bits()), 64'h4);
    next_cycle();
    clear_all();
    drive_device(2, 1'b1, 32'h0, 1'b1);
    #1;
    check_output("tmr_rvalid", 64'(host_rvalid_o[1]), 64'h1);
    check_output("tmr_err", 64'(host_err_o[1]), 64'h1);
    check_output("tmr_err_other", 64'(host_err_o[0]), 64'h0);
    next_cycle();
    clear_all();

    // Back-to-back RAM then Timer
    drive_host(0, 1'b1, 32'h0010_0010, 1'b0, 4'hF, 32'h0);
    #1;
    check_output("b2b_dreq_ram", 64'(dreq_bits()), 64'h1);
    next_cycle();
    drive_host(0, 1'b1, 32'h0003_0004, 1'b0, 4'hF, 32'h0);
    drive_device(0, 1'b1, 32'hAAAA_0001, 1'b0);
    drive_device(2, 1'b0, 32'hEEEE_EEEE, 1'b0);
    #1;
    check_output("b2b_dreq_tmr", 64'(dreq_bits()), 64'h4);
    check_output("b2b_rdata_ram", 64'(host_rdata_o[0]), 64'hAAAA_0001);
    check_output("b2b_rvalid_ram", 64'(host_rvalid_o[0]), 64'h1);
    next_cycle();
    host_req_i[0] = 1'b0;
    drive_device(0, 1'b0, 32'hCCCC_CCCC, 1'b0);
    drive_device(2, 1'b1, 32'hBBBB_0002, 1'b0);
    #1;
    check_output("b2b_rvalid_tmr", 64'(host_rvalid_o[0]), 64'h1);
    check_output("b2b_rdata_tmr", 64'(host_rdata_o[0]), 64'hBBBB_0002);
    next_cycle();
    clear_all();

    // Reset between grant and response drops the response
    drive_host(1, 1'b1, 32'h0003_0000, 1'b0, 4'hF, 32'h0);
    #1;
    check_output("rst_gnt", 64'(gnt_bits()), 64'h2);
    next_cycle();
    clear_all();
    rst_ni = 1'b0;
    drive_device(2, 1'b1, 32'h5555_0000, 1'b0);
    #1;
    check_output("rst_drop_rvalid1", 64'(host_rvalid_o[1]), 64'h0);
    check_output("rst_drop_rvalid0", 64'(host_rvalid_o[0]), 64'h0);
    device_rvalid_i[0] = 1'b1;
    #1;
    check_output("rst_rvalid0_follows_dev0", 64'(host_rvalid_o[0]), 64'h1);
    clear_all();
    #5 rst_ni = 1'b1;
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/host_device_bus.md
# host_device_bus

Single-layer, combinational-request, registered-response interconnect between N bus hosts (e.g. a core data port) and M memory-mapped devices (RAM, simulator control, timer). Each cycle it arbitrates among requesting hosts with a fixed priority and decodes the winner's address against per-device base/mask pairs. It forwards the request to exactly one device and routes that device's response back to the originating host one cycle later. It sits between the core's data interface and the peripherals in the simple system.

## Interface
Parameters:
- NrDevices, default 1: number of device ports (>=1).
- NrHosts, default 1: number of host ports (>=1).
- DataWidth, default 32: data bus width in bits.
- AddressWidth, default 32: address width in bits.

Ports (all host_*/device_*/cfg_* are unpacked arrays indexed [NrHosts] or [NrDevices]):
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset; one clock, asynchronous, active-low.
- host_req_i  in  1 per host  request valid.
- host_gnt_o  out  1 per host  request accepted this cycle.
- host_addr_i  in  AddressWidth per host  byte address.
- host_we_i  in  1 per host  1 = write, 0 = read.
- host_be_i  in  DataWidth/8 per host  byte enables.
- host_wdata_i  in  DataWidth per host  write data.
- host_rvalid_o  out  1 per host  response valid.
- host_rdata_o  out  DataWidth per host  read data.
- host_err_o  out  1 per host  response error.
- device_req_o  out  1 per device  request strobe.
- device_addr_o  out  AddressWidth per device  forwarded address.
- device_we_o  out  1 per device  forwarded write enable.
- device_be_o  out  DataWidth/8 per device  forwarded byte enables.
- device_wdata_o  out  DataWidth per device  forwarded write data.
- device_rvalid_i  in  1 per device  device response valid.
- device_rdata_i  in  DataWidth per device  device read data.
- device_err_i  in  1 per device  device error.
- cfg_device_addr_base  in  AddressWidth per device  region base.
- cfg_device_addr_mask  in  AddressWidth per device  region mask.

## Operation
- Arbitration is combinational with fixed priority: the lowest-indexed host with host_req_i=1 wins (host_sel_req). No fairness.
- Decode compares the winner's address: device d matches when (addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]. On overlapping matches, the lowest index wins.
- host_gnt_o[h] = host_req_i[h] && h is the winner. All losing hosts see gnt=0 and must hold their request.
- device_req_o[d] = 1 only for the decoded device of a granted request. addr/we/be/wdata of the winning host are driven to all device ports; only req is qualified.
- Unmapped address: the request is still granted, no device_req_o is asserted, and an error response is generated internally.
- Response routing uses registered state, captured on every granted request: resp_host, resp_device, and resp_unmapped.
- host_rvalid_o[h] = (h == resp_host) && device_rvalid_i[resp_device].
- host_err_o[h] and host_rdata_o[h] are taken from the same device. Non-selected hosts get rvalid=0, err=0, rdata=0.
- For an unmapped access the selected host gets rvalid=1, err=1 and rdata=0 in the response cycle.
- Devices must respond exactly one cycle after their req. The bus does not track outstanding counts beyond one transaction per cycle, and back-to-back requests pipeline.

## Timing
- Request path (gnt, device_req and forwarded fields) is purely combinational from host inputs and cfg inputs: zero latency.
- Response path is combinational from device_rvalid_i/rdata_i/err_i, steered by state registered at the grant edge. The host sees its response in cycle N+1 for a grant in cycle N.
- Reset values: resp_host=0, resp_device=0, resp_unmapped=0.
- During and immediately after reset, host_rvalid_o follows device_rvalid_i[0] for host 0 and is 0 for all other hosts; host_err_o is 0 unless the device signals an error.
- If reset asserts mid-transaction, the pending response is dropped and routing state returns to reset values asynchronously.
- A grant in cycle N+1 updates routing for N+2 without disturbing the response delivered in N+1.

## Test plan
- Single host, read at 0x100004 (RAM base 0x100000, mask ~0xFFFFF) -> gnt=1 same cycle, device_req[0]=1; RAM rdata 0xDEADBEEF next cycle -> host_rvalid=1, rdata=0xDEADBEEF, err=0.
- Write 0x41 with be=4'b0001 to 0x20000 (SimCtrl) -> only device_req[1]=1, device_we=1, device_wdata=0x41, device_be=0001; no response to other hosts.
- Two hosts request the same cycle -> host 0 gnt=1, host 1 gnt=0; host 1 holds its request and is granted the next cycle.
- Access to 0x50000 (unmapped) -> gnt=1, no device_req; next cycle host_rvalid=1, err=1, rdata=0.
- Timer (device 2) returns err=1 for a 0x30008 access -> host_err=1 with rvalid=1 one cycle after grant.
- Back-to-back reads RAM then Timer in consecutive cycles -> responses return in order, each steered from the correct device; assert rst_ni between grant and response -> no rvalid on the host.
